// File: rtl/pong_pkg.sv
// Shared pong geometry and ball state encoding.
// Positions are top-left corners in visible-pixel coordinates.
package pong_pkg;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned BALL_SIZE  = 8;
  localparam int unsigned WALL_X_R   = 35;
  localparam int unsigned PADDLE_X_L = 600;
  localparam int unsigned PADDLE_X_R = 603;
  localparam int unsigned PADDLE_H   = 72;

  typedef enum logic [0:0] {
    StServe,
    StPlay
  } ball_state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the end-of-frame level from the sync generator into a one-clk tick
// on its rising edge, however long the level stays high.
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic v_end,
  output logic tick
);

  logic v_end_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_end_q <= 1'b0;
    end else begin
      v_end_q <= v_end;
    end
  end

  assign tick = v_end & ~v_end_q;

endmodule

// File: rtl/ball_ctrl.sv
// Ball motion and collision engine: serve hold, wall/paddle bounces and miss
// detection, advancing once per video frame.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned BALL_V       = 2,
  parameter int unsigned SERVE_X      = 320,
  parameter int unsigned SERVE_Y      = 240,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_end,
  input  logic [9:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit,
  output logic       miss
);

  localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0] MissX   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] WallX   = 11'(WALL_X_R + 1 + BALL_V);
  localparam logic [10:0] TopY    = 11'(BALL_V);
  localparam logic [10:0] BotY    = 11'(SCREEN_H - BALL_SIZE - BALL_V);
  localparam logic [10:0] Edge    = 11'(BALL_SIZE - 1);
  localparam logic [10:0] PadL    = 11'(PADDLE_X_L);
  localparam logic [10:0] PadR    = 11'(PADDLE_X_R);
  localparam logic [10:0] PadSpan = 11'(PADDLE_H - 1);
  localparam logic signed [10:0] Speed = 11'(BALL_V);

  logic tick;

  ball_state_e     state_q, state_d;
  logic [CntW-1:0] serve_cnt_q, serve_cnt_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            vx_pos_q, vx_pos_d, vy_pos_q, vy_pos_d;
  logic            serve_dir_q, serve_dir_d;
  logic            hit_q, hit_d, miss_q, miss_d;

  logic [10:0] x_ext, y_ext, x_right, y_bot, pad_top, pad_bot;
  logic        on_paddle;
  logic signed [10:0] step_x, step_y;

  frame_tick_gen u_frame_tick_gen (
    .clk   (clk),
    .reset (reset),
    .v_end (v_end),
    .tick  (tick)
  );

  assign x_ext   = {1'b0, x_q};
  assign y_ext   = {1'b0, y_q};
  assign x_right = x_ext + Edge;
  assign y_bot   = y_ext + Edge;
  assign pad_top = {1'b0, paddle_y};
  assign pad_bot = pad_top + PadSpan;

  // Only a ball moving right can strike the paddle face.
  assign on_paddle = vx_pos_q && (x_right >= PadL) && (x_right <= PadR) &&
                     (y_bot >= pad_top) && (y_ext <= pad_bot);

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    vx_pos_d    = vx_pos_q;
    vy_pos_d    = vy_pos_q;
    serve_dir_d = serve_dir_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    step_x      = Speed;
    step_y      = Speed;

    if (tick) begin
      unique case (state_q)
        StServe: begin
          if (serve_cnt_q == CntW'(SERVE_FRAMES - 1)) begin
            state_d     = StPlay;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + CntW'(1);
          end
        end
        StPlay: begin
          if (x_ext >= MissX) begin
            miss_d      = 1'b1;
            state_d     = StServe;
            x_d         = 10'(SERVE_X);
            y_d         = 10'(SERVE_Y);
            serve_dir_d = ~serve_dir_q;
            vx_pos_d    = 1'b1;
            vy_pos_d    = ~serve_dir_q;
          end else begin
            if (on_paddle) begin
              vx_pos_d = 1'b0;
              hit_d    = 1'b1;
            end else if (x_ext < WallX) begin
              vx_pos_d = 1'b1;
            end
            if (y_ext < TopY) begin
              vy_pos_d = 1'b1;
            end else if (y_ext > BotY) begin
              vy_pos_d = 1'b0;
            end
            // New velocity applies this same frame so bounces never overshoot.
            step_x = vx_pos_d ? Speed : -Speed;
            step_y = vy_pos_d ? Speed : -Speed;
            x_d    = 10'($signed(x_ext) + step_x);
            y_d    = 10'($signed(y_ext) + step_y);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StServe;
      serve_cnt_q <= '0;
      x_q         <= 10'(SERVE_X);
      y_q         <= 10'(SERVE_Y);
      vx_pos_q    <= 1'b1;
      vy_pos_q    <= 1'b0;
      serve_dir_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vx_pos_q    <= vx_pos_d;
      vy_pos_q    <= vy_pos_d;
      serve_dir_q <= serve_dir_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign hit    = hit_q;
  assign miss   = miss_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: frames of random v_end width checked against a
// frame-level model of the ball rules.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       v_end;
  logic [9:0] paddle_y;
  logic [9:0] ball_x, ball_y;
  logic       hit, miss;

  ball_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .v_end    (v_end),
    .paddle_y (paddle_y),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .hit      (hit),
    .miss     (miss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;

  // Model state, one update per frame.
  bit m_play, m_dir;
  int m_cnt, m_x, m_y, m_vx, m_vy;

  // What the bench saw for the latest frame.
  logic [9:0] obs_x, obs_y;
  logic       obs_hit, obs_miss;
  bit         obs_extra, obs_drift;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_play = 0; m_dir = 0; m_cnt = 0;
    m_x = 320; m_y = 240; m_vx = 2; m_vy = -2;
    tick_no = 0;
  endtask

  task automatic model_tick(input int py, output bit h, output bit mi);
    h = 0;
    mi = 0;
    if (!m_play) begin
      m_cnt++;
      if (m_cnt == 60) begin
        m_play = 1;
        m_cnt  = 0;
      end
      return;
    end
    if (m_x >= 640 - 8) begin
      mi = 1; m_play = 0; m_x = 320; m_y = 240;
      m_dir = !m_dir; m_vx = 2; m_vy = m_dir ? 2 : -2;
      return;
    end
    if (m_vx > 0 && m_x + 7 >= 600 && m_x + 7 <= 603 && m_y + 7 >= py && m_y <= py + 71) begin
      m_vx = -2;
      h = 1;
    end else if (m_x < 35 + 1 + 2) begin
      m_vx = 2;
    end
    if (m_y < 2) m_vy = 2;
    else if (m_y > 480 - 8 - 2) m_vy = -2;
    m_x += m_vx;
    m_y += m_vy;
  endtask

  task automatic do_reset();
    reset = 1; v_end = 0;
    step();
    step();
    reset = 0;
    model_reset();
  endtask

  // One frame: v_end high for hi clks then low for lo clks (lo >= 1).
  task automatic do_frame(input int hi, input int lo);
    v_end = 1;
    step();
    obs_x = ball_x; obs_y = ball_y; obs_hit = hit; obs_miss = miss;
    obs_extra = 0; obs_drift = 0;
    for (int i = 1; i < hi + lo; i++) begin
      if (i == hi) v_end = 0;
      step();
      if (hit || miss) obs_extra = 1;
      if (ball_x != obs_x || ball_y != obs_y) obs_drift = 1;
    end
  endtask

  task automatic run_to(input int last, input int py, input string tag);
    bit eh, em;
    paddle_y = 10'(py);
    while (tick_no < last) begin
      do_frame($urandom_range(1, 4), $urandom_range(1, 3));
      model_tick(py, eh, em);
      tick_no++;
      n_checks++;
      if (obs_x !== 10'(m_x) || obs_y !== 10'(m_y) || obs_hit !== eh || obs_miss !== em) begin
        n_fail++;
        $display("FAIL %s tick=%0d got=(%0d,%0d) hit=%b miss=%b want=(%0d,%0d) hit=%b miss=%b",
                 tag, tick_no, obs_x, obs_y, obs_hit, obs_miss, m_x, m_y, eh, em);
      end
      n_checks++;
      if (obs_extra !== 1'b0 || obs_drift !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_quiet tick=%0d got extra=%b drift=%b want 0 0",
                 tag, tick_no, obs_extra, obs_drift);
      end
    end
  endtask

  task automatic test_reset();
    paddle_y = 10'd0;
    do_reset();
    n_checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
      n_fail++;
      $display("FAIL reset_pos got=(%0d,%0d) want=(320,240)", ball_x, ball_y);
    end
    n_checks++;
    if (hit !== 1'b0 || miss !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse got hit=%b miss=%b want 0 0", hit, miss);
    end
  endtask

  task automatic test_long_vend();
    bit eh, em;
    do_frame(800, 4);
    model_tick(0, eh, em);
    tick_no++;
    n_checks++;
    if (obs_x !== 10'd320 || obs_y !== 10'd240 || obs_drift !== 1'b0) begin
      n_fail++;
      $display("FAIL long_vend_pos got=(%0d,%0d) drift=%b want=(320,240) 0",
               obs_x, obs_y, obs_drift);
    end
    n_checks++;
    if (obs_hit !== 1'b0 || obs_miss !== 1'b0 || obs_extra !== 1'b0) begin
      n_fail++;
      $display("FAIL long_vend_pulse got hit=%b miss=%b extra=%b want 0", obs_hit, obs_miss,
               obs_extra);
    end
  endtask

  task automatic test_serve_delay();
    run_to(60, 0, "serve");
    n_checks++;
    if (obs_x !== 10'd320 || obs_y !== 10'd240) begin
      n_fail++;
      $display("FAIL serve_hold got=(%0d,%0d) want=(320,240)", obs_x, obs_y);
    end
    run_to(61, 0, "serve");
    n_checks++;
    if (obs_x !== 10'd322 || obs_y !== 10'd238) begin
      n_fail++;
      $display("FAIL serve_first_move got=(%0d,%0d) want=(322,238)", obs_x, obs_y);
    end
  endtask

  task automatic test_top_bounce();
    run_to(180, 0, "top");
    n_checks++;
    if (obs_x !== 10'd560 || obs_y !== 10'd0) begin
      n_fail++;
      $display("FAIL top_reach got=(%0d,%0d) want=(560,0)", obs_x, obs_y);
    end
    run_to(182, 0, "top");
    n_checks++;
    if (obs_x !== 10'd564 || obs_y !== 10'd4) begin
      n_fail++;
      $display("FAIL top_after got=(%0d,%0d) want=(564,4)", obs_x, obs_y);
    end
  endtask

  task automatic test_paddle_hit();
    run_to(197, 0, "paddle");
    n_checks++;
    if (obs_x !== 10'd594 || obs_y !== 10'd34 || obs_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL paddle_approach got=(%0d,%0d) hit=%b want=(594,34) 0", obs_x, obs_y, obs_hit);
    end
    run_to(198, 0, "paddle");
    n_checks++;
    if (obs_hit !== 1'b1 || obs_extra !== 1'b0 || obs_x !== 10'd592 || obs_y !== 10'd36) begin
      n_fail++;
      $display("FAIL paddle_hit got=(%0d,%0d) hit=%b extra=%b want=(592,36) 1 0",
               obs_x, obs_y, obs_hit, obs_extra);
    end
  endtask

  task automatic test_miss();
    do_reset();
    run_to(216, 400, "miss");
    n_checks++;
    if (obs_x !== 10'd632 || obs_y !== 10'd72) begin
      n_fail++;
      $display("FAIL miss_reach got=(%0d,%0d) want=(632,72)", obs_x, obs_y);
    end
    run_to(217, 400, "miss");
    n_checks++;
    if (obs_miss !== 1'b1 || obs_hit !== 1'b0 || obs_extra !== 1'b0 ||
        obs_x !== 10'd320 || obs_y !== 10'd240) begin
      n_fail++;
      $display("FAIL miss_pulse got=(%0d,%0d) miss=%b hit=%b extra=%b want=(320,240) 1 0 0",
               obs_x, obs_y, obs_miss, obs_hit, obs_extra);
    end
    run_to(277, 400, "reserve");
    n_checks++;
    if (obs_x !== 10'd320 || obs_y !== 10'd240) begin
      n_fail++;
      $display("FAIL reserve_hold got=(%0d,%0d) want=(320,240)", obs_x, obs_y);
    end
    run_to(278, 400, "reserve");
    n_checks++;
    if (obs_x !== 10'd322 || obs_y !== 10'd242) begin
      n_fail++;
      $display("FAIL reserve_move got=(%0d,%0d) want=(322,242)", obs_x, obs_y);
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    run_to(99, 400, "midplay");
    // Reset lands in the same cycle as the rising v_end edge of tick 100.
    v_end = 1; reset = 1;
    step();
    reset = 0; v_end = 0;
    model_reset();
    n_checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240 || hit !== 1'b0 || miss !== 1'b0) begin
      n_fail++;
      $display("FAIL midplay_reset got=(%0d,%0d) hit=%b miss=%b want=(320,240) 0 0",
               ball_x, ball_y, hit, miss);
    end
    step();
    n_checks++;
    if (hit !== 1'b0 || miss !== 1'b0) begin
      n_fail++;
      $display("FAIL midplay_pulse got hit=%b miss=%b want 0 0", hit, miss);
    end
    run_to(60, 400, "midplay_serve");
    n_checks++;
    if (obs_x !== 10'd320 || obs_y !== 10'd240) begin
      n_fail++;
      $display("FAIL midplay_hold got=(%0d,%0d) want=(320,240)", obs_x, obs_y);
    end
    run_to(61, 400, "midplay_serve");
    n_checks++;
    if (obs_x !== 10'd322 || obs_y !== 10'd238) begin
      n_fail++;
      $display("FAIL midplay_move got=(%0d,%0d) want=(322,238)", obs_x, obs_y);
    end
  endtask

  task automatic test_random();
    bit eh, em;
    int py;
    do_reset();
    py = 0;
    for (int t = 0; t < 1500; t++) begin
      // Half the time park the paddle around the ball so hits actually occur.
      if (t % 8 == 0) begin
        if ($urandom_range(0, 1) == 1) py = int'($urandom_range(0, 700));
        else py = (m_y > 60) ? m_y - int'($urandom_range(0, 60)) : 0;
      end
      paddle_y = 10'(py);
      do_frame($urandom_range(1, 4), $urandom_range(1, 3));
      model_tick(py, eh, em);
      tick_no++;
      n_checks++;
      if (obs_x !== 10'(m_x) || obs_y !== 10'(m_y) || obs_hit !== eh || obs_miss !== em) begin
        n_fail++;
        $display("FAIL random tick=%0d py=%0d got=(%0d,%0d) hit=%b miss=%b want=(%0d,%0d) hit=%b miss=%b",
                 tick_no, py, obs_x, obs_y, obs_hit, obs_miss, m_x, m_y, eh, em);
      end
      n_checks++;
      if (obs_extra !== 1'b0 || obs_drift !== 1'b0 || (obs_hit && obs_miss)) begin
        n_fail++;
        $display("FAIL random_quiet tick=%0d got extra=%b drift=%b both=%b want 0 0 0",
                 tick_no, obs_extra, obs_drift, obs_hit && obs_miss);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    v_end = 1'b0;
    paddle_y = 10'd0;
    test_reset();
    test_long_vend();
    test_serve_delay();
    test_top_bounce();
    test_paddle_hit();
    test_miss();
    test_reset_mid_play();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
